// File: rtl/stm32h7_pssi_pkg.sv
// Shared constants and types for the STM32H7 PSSI receive path.
package stm32h7_pssi_pkg;

    localparam int unsigned PSSI_BUS_W     = 8;
    localparam int unsigned PSSI_WORD_W    = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int unsigned SYNC_STAGES    = 2;

    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

    localparam byte_idx_t LANE0 = BYTE_IDX_W'(0);
    localparam byte_idx_t LANE1 = BYTE_IDX_W'(1);
    localparam byte_idx_t LANE2 = BYTE_IDX_W'(2);
    localparam byte_idx_t LANE3 = BYTE_IDX_W'(3);

    // Pin bundle kept together so all PSSI inputs share one synchroniser chain.
    typedef struct packed {
        logic                  clk;
        logic                  de;
        logic [PSSI_BUS_W-1:0] data;
    } pssi_pins_t;

endpackage

// File: rtl/pssi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is taken only alongside a pop.
module pssi_rx_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] rd_data_c_o,
    output logic [CW-1:0]    count_nxt_c_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             wr_en_c, rd_en_c;

    always_comb begin
        wr_en_c = push_i & (~full_q | pop_i);
        rd_en_c = pop_i & ~empty_q;
        count_d = count_q + CW'(wr_en_c) - CW'(rd_en_c);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_en_c) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rd_data_c_o   = mem_q[rd_ptr_q];
    assign count_nxt_c_o = count_d;
    assign full_o        = full_q;
    assign empty_o       = empty_q;

endmodule

// File: rtl/stm32h7_pssi_rx_8bus_32bits.sv
// PSSI receiver: oversamples the MCU's 8-bit PSSI bus, packs little-endian 32-bit words
// into a FIFO and exposes them on a valid/ready stream, with back-pressure via pssi_rdy_o.
module stm32h7_pssi_rx_8bus_32bits
    import stm32h7_pssi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RDY_MARGIN = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pssi_clk_i,
    input  logic                   pssi_de_i,
    input  logic [PSSI_BUS_W-1:0]  pssi_data_i,
    output logic                   pssi_rdy_o,
    output logic [PSSI_WORD_W-1:0] fpga_data_o,
    output logic                   fpga_valid_o,
    input  logic                   fpga_ready_i,
    output logic                   frame_err_o
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SHIFT_W = PSSI_WORD_W - PSSI_BUS_W;

    pssi_pins_t               pins_c, synced_c;
    pssi_pins_t               sync_q [SYNC_STAGES];
    logic                     clk_prev_q, de_prev_q;
    logic                     rise_c, de_fall_c;

    byte_idx_t                byte_cnt_q, byte_cnt_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;
    logic [PSSI_WORD_W-1:0]   word_c;
    logic                     push_c, pop_c;
    logic                     frame_err_q, frame_err_d;
    logic                     rdy_q, rdy_d;

    logic [CNT_W-1:0]         fifo_cnt_nxt_c;
    logic                     fifo_full, fifo_empty;

    assign pins_c   = '{clk: pssi_clk_i, de: pssi_de_i, data: pssi_data_i};
    assign synced_c = sync_q[SYNC_STAGES-1];

    // Identical synchroniser depth on every pin keeps clock, enable and data aligned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            clk_prev_q <= 1'b0;
            de_prev_q  <= 1'b0;
        end else begin
            sync_q[0] <= pins_c;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            clk_prev_q <= synced_c.clk;
            de_prev_q  <= synced_c.de;
        end
    end

    assign rise_c    = synced_c.clk & ~clk_prev_q;
    assign de_fall_c = de_prev_q & ~synced_c.de;
    assign pop_c     = fpga_ready_i & ~fifo_empty;
    assign word_c    = {synced_c.data, shift_q};

    // Byte packer plus partial-frame and overflow error detection.
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        push_c      = 1'b0;
        frame_err_d = 1'b0;
        if (rise_c && synced_c.de) begin
            byte_cnt_d = byte_cnt_q + BYTE_IDX_W'(1);
            case (byte_cnt_q)
                LANE0:   shift_d[PSSI_BUS_W-1:0]              = synced_c.data;
                LANE1:   shift_d[2*PSSI_BUS_W-1:PSSI_BUS_W]   = synced_c.data;
                LANE2:   shift_d[3*PSSI_BUS_W-1:2*PSSI_BUS_W] = synced_c.data;
                LANE3:   push_c                               = 1'b1;
                default: push_c                               = 1'b0;
            endcase
        end else if (de_fall_c && (byte_cnt_q != LANE0)) begin
            byte_cnt_d  = LANE0;
            frame_err_d = 1'b1;
        end
        if (push_c && fifo_full && !pop_c) begin
            frame_err_d = 1'b1;
        end
    end

    assign rdy_d = (fifo_cnt_nxt_c < CNT_W'(FIFO_DEPTH - RDY_MARGIN));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q  <= LANE0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            rdy_q       <= rdy_d;
        end
    end

    pssi_rx_fifo #(
        .WIDTH (PSSI_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (push_c),
        .pop_i         (pop_c),
        .data_i        (word_c),
        .rd_data_c_o   (fpga_data_o),
        .count_nxt_c_o (fifo_cnt_nxt_c),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty)
    );

    assign fpga_valid_o = ~fifo_empty;
    assign pssi_rdy_o   = rdy_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_stm32h7_pssi_rx_8bus_32bits.sv
// Scoreboard bench for the PSSI receiver: expected words queued at send time, compared on handshake.
module tb_stm32h7_pssi_rx_8bus_32bits;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pssi_clk, pssi_de;
    logic [7:0]  pssi_data;
    logic        fpga_ready;
    logic        pssi_rdy;
    logic [31:0] fpga_data;
    logic        fpga_valid;
    logic        frame_err;

    int          errors = 0;
    int          checks = 0;
    int          err_pulses = 0;
    logic [31:0] exp_q [$];

    stm32h7_pssi_rx_8bus_32bits #(
        .FIFO_DEPTH (8),
        .RDY_MARGIN (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pssi_clk_i   (pssi_clk),
        .pssi_de_i    (pssi_de),
        .pssi_data_i  (pssi_data),
        .pssi_rdy_o   (pssi_rdy),
        .fpga_data_o  (fpga_data),
        .fpga_valid_o (fpga_valid),
        .fpga_ready_i (fpga_ready),
        .frame_err_o  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
    end

    // Handshake monitor: the transfer completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && fpga_valid && fpga_ready) begin
            if (exp_q.size() == 0) check("spurious_word", 32'(exp_q.size()), 32'd1);
            else                   check("word", fpga_data, exp_q.pop_front());
        end
    end

    // One PSSI beat: data set up while pssi_clk is low, captured on its rising edge.
    task automatic send_byte(input logic [7:0] b, input bit pop_at_capture);
        pssi_clk  = 1'b0;
        pssi_data = b;
        pssi_de   = 1'b1;
        #40;
        pssi_clk = 1'b1;
        fork
            #40;
            if (pop_at_capture) begin
                #16 fpga_ready = 1'b1;
                #10 fpga_ready = 1'b0;
            end
        join
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_it, input bit pop_last);
        if (expect_it) exp_q.push_back(w);
        for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8], 1'b0);
        send_byte(w[31:24], pop_last);
    endtask

    task automatic de_low();
        pssi_clk = 1'b0;
        pssi_de  = 1'b0;
        #80;
    endtask

    task automatic set_ready(input logic v);
        #6 fpga_ready = v;
        #4;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            #10;
        end
        #20;
        check(tag, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid"}, 32'(fpga_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        pssi_clk   = 1'b0;
        pssi_de    = 1'b0;
        pssi_data  = 8'h00;
        fpga_ready = 1'b0;
        #22;
        check("rst_rdy",   32'(pssi_rdy),   32'd0);
        check("rst_valid", 32'(fpga_valid), 32'd0);
        check("rst_data",  fpga_data,       32'd0);
        check("rst_err",   32'(frame_err),  32'd0);
        #10 rst_n = 1'b1;
        #8;
        check("rdy_after_rst", 32'(pssi_rdy), 32'd1);

        // Single word, then one-cycle pop.
        send_word(32'h44332211, 1'b1, 1'b0);
        check("single_valid", 32'(fpga_valid), 32'd1);
        check("single_data",  fpga_data,       32'h44332211);
        de_low();
        set_ready(1'b1);
        #10;
        check("single_drop", 32'(fpga_valid), 32'd0);
        set_ready(1'b0);
        check("single_no_err", 32'(err_pulses), 32'd0);

        // Back-pressure: rdy drops once 6 of 8 slots are used.
        for (int k = 1; k <= 8; k++) begin
            send_word(32'hA0B0C000 | 32'(k), 1'b1, 1'b0);
            check($sformatf("bp_rdy_w%0d", k), 32'(pssi_rdy), (k < 6) ? 32'd1 : 32'd0);
        end
        check("bp_no_err", 32'(err_pulses), 32'd0);

        // Overflow: 9th word is dropped.
        send_word(32'hDEAD0009, 1'b0, 1'b0);
        check("ovf_err", 32'(err_pulses), 32'd1);

        // Push and pop together while full.
        send_word(32'hBEEF000A, 1'b1, 1'b1);
        check("sim_rdy",    32'(pssi_rdy),   32'd0);
        check("sim_valid",  32'(fpga_valid), 32'd1);
        check("sim_no_err", 32'(err_pulses), 32'd1);
        de_low();
        set_ready(1'b1);
        wait_drain("ovf_drain");

        // Partial frame discarded, next word intact.
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        de_low();
        check("partial_err", 32'(err_pulses), 32'd2);
        send_word(32'h04030201, 1'b1, 1'b0);
        de_low();
        wait_drain("partial_drain");
        check("partial_no_extra_err", 32'(err_pulses), 32'd2);

        // Reset in the middle of a word.
        set_ready(1'b0);
        send_word(32'hCAFEF00D, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(fpga_valid), 32'd1);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hC3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rdy",   32'(pssi_rdy),   32'd0);
        check("midrst_valid", 32'(fpga_valid), 32'd0);
        check("midrst_data",  fpga_data,       32'd0);
        check("midrst_err",   32'(frame_err),  32'd0);
        pssi_clk = 1'b0;
        pssi_de  = 1'b0;
        exp_q.delete();
        #29 rst_n = 1'b1;
        #8;
        check("post_rst_rdy", 32'(pssi_rdy), 32'd1);
        set_ready(1'b1);
        send_word(32'h87654321, 1'b1, 1'b0);
        de_low();
        wait_drain("post_rst_drain");
        check("err_total", 32'(err_pulses), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
